// File: rtl/sine_gen.sv
// Phase-accumulator waveform generator: sine/square/sawtooth/triangle samples in 0..99,
// with a one-deep config handshake that retunes the generator on a period boundary.
module sine_gen #(
   parameter int PHASE_W = 16,
   parameter int ADDR_W  = 8,
   parameter int OUT_W   = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [PHASE_W-1:0] cfg_incr,
   input  logic [1:0]         cfg_mode,
   output logic               sample_valid,
   output logic [OUT_W-1:0]   sample_out,
   output logic               wrap
);

   localparam int  DEPTH = 2**ADDR_W;
   localparam real PI    = 3.14159265358979323846;

   typedef enum logic {RUN, PENDING} cfg_state_e;

   function automatic logic [6:0] sine_val(input int i);
      real v;
      v = 50.0 + 49.5 * $sin(2.0 * PI * real'(i) / real'(DEPTH));
      return 7'($rtoi($floor(v)));
   endfunction

   function automatic logic [6:0] saw_val(input logic [ADDR_W-1:0] a);
      logic [ADDR_W+6:0] p;
      p = {7'd0, a} * (ADDR_W+7)'(100);
      return p[ADDR_W +: 7];
   endfunction

   function automatic logic [6:0] tri_val(input logic [ADDR_W-1:0] a);
      logic [ADDR_W+5:0] p;
      logic [6:0]        t;
      p = {7'd0, a[ADDR_W-2:0]} * (ADDR_W+6)'(100);
      t = p[ADDR_W-1 +: 7];
      return a[ADDR_W-1] ? 7'd99 - t : t;
   endfunction

   cfg_state_e         state_reg, state_next;
   logic               live_reg;
   logic [PHASE_W-1:0] acc_reg, incr_reg, incr_pend_reg;
   logic [1:0]         mode_reg, mode_pend_reg;
   logic               carry_seen_reg;
   logic [PHASE_W:0]   sum;
   logic               carry;
   logic               accept, apply;

   logic               s1_valid_reg, s1_wrap_reg;
   logic [ADDR_W-1:0]  s1_addr_reg;
   logic [1:0]         s1_mode_reg;
   logic [6:0]         wave;

   logic [6:0] sine_rom [DEPTH];

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
         assign sine_rom[gi] = sine_val(gi);
      end
   endgenerate

   assign sum   = {1'b0, acc_reg} + {1'b0, incr_reg};
   assign carry = enable & sum[PHASE_W];

   // A zero increment can never wrap, so a pending config is taken on the next edge instead.
   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      apply      = 1'b0;
      cfg_ready  = live_reg && (state_reg == RUN);
      case (state_reg)
         RUN: begin
            if (cfg_valid && live_reg) begin
               accept     = 1'b1;
               state_next = PENDING;
            end
         end
         PENDING: begin
            if ((incr_reg == '0) || carry) begin
               apply      = 1'b1;
               state_next = RUN;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= RUN;
         live_reg       <= 1'b0;
         acc_reg        <= '0;
         incr_reg       <= '0;
         mode_reg       <= '0;
         incr_pend_reg  <= '0;
         mode_pend_reg  <= '0;
         carry_seen_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         live_reg  <= 1'b1;
         if (enable) begin
            acc_reg        <= sum[PHASE_W-1:0];
            carry_seen_reg <= carry;
         end
         if (accept) begin
            incr_pend_reg <= cfg_incr;
            mode_pend_reg <= cfg_mode;
         end
         if (apply) begin
            incr_reg <= incr_pend_reg;
            mode_reg <= mode_pend_reg;
         end
      end
   end

   always_comb begin
      wave = sine_rom[s1_addr_reg];
      case (s1_mode_reg)
         2'd1:    wave = s1_addr_reg[ADDR_W-1] ? 7'd0 : 7'd99;
         2'd2:    wave = saw_val(s1_addr_reg);
         2'd3:    wave = tri_val(s1_addr_reg);
         default: ;
      endcase
   end

   // The wrap tag rides with the first sample taken from the post-carry phase.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_reg <= 1'b0;
         s1_wrap_reg  <= 1'b0;
         s1_addr_reg  <= '0;
         s1_mode_reg  <= '0;
         sample_valid <= 1'b0;
         sample_out   <= '0;
         wrap         <= 1'b0;
      end else begin
         s1_valid_reg <= enable;
         if (enable) begin
            s1_addr_reg <= acc_reg[PHASE_W-1 -: ADDR_W];
            s1_mode_reg <= mode_reg;
            s1_wrap_reg <= carry_seen_reg;
         end
         sample_valid <= s1_valid_reg;
         wrap         <= s1_valid_reg & s1_wrap_reg;
         if (s1_valid_reg) begin
            sample_out <= OUT_W'(wave);
         end
      end
   end

endmodule

// File: tb/tb_sine_gen.sv
// Testbench for sine_gen: directed scenarios plus random stimulus, checked every cycle
// against a behavioural model of the generator and its config handshake.
module tb_sine_gen;
   localparam int     PW    = 16;
   localparam int     AW    = 8;
   localparam int     OW    = 8;
   localparam int     DEPTH = 256;
   localparam longint MODV  = longint'(1) << PW;
   localparam real    PI    = 3.14159265358979323846;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          enable = 1'b0;
   logic          cfg_valid = 1'b0;
   logic          cfg_ready;
   logic [PW-1:0] cfg_incr = '0;
   logic [1:0]    cfg_mode = '0;
   logic          sample_valid;
   logic [OW-1:0] sample_out;
   logic          wrap;

   sine_gen #(.PHASE_W(PW), .ADDR_W(AW), .OUT_W(OW)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_incr(cfg_incr), .cfg_mode(cfg_mode),
      .sample_valid(sample_valid), .sample_out(sample_out), .wrap(wrap)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int sine_tab [DEPTH];
   int log_out [$];
   bit log_wrap [$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   function automatic int wave_of(input int mode, input int addr);
      int half;
      int t;
      half = DEPTH / 2;
      case (mode)
         0: return sine_tab[addr];
         1: return (addr < half) ? 99 : 0;
         2: return addr * 100 / DEPTH;
         default: begin
            t = (addr % half) * 100 / half;
            return (addr < half) ? t : 99 - t;
         end
      endcase
   endfunction

   // Behavioural model state
   typedef struct {bit v; int val; bit w;} samp_t;
   samp_t  pipe [$];
   longint m_acc, m_incr, m_pincr;
   int     m_mode, m_pmode, m_out;
   bit     m_pending, m_live, m_cflag, m_ready, m_valid, m_wrap;

   task automatic model_edge();
      samp_t  e, o;
      bit     carry, accept;
      longint sum;
      e = '{1'b0, 0, 1'b0};
      if (reset) begin
         m_acc = 0; m_incr = 0; m_pincr = 0; m_mode = 0; m_pmode = 0;
         m_pending = 0; m_live = 0; m_cflag = 0;
         pipe.delete();
         pipe.push_back(e);
         m_valid = 0; m_out = 0; m_wrap = 0; m_ready = 0;
         return;
      end
      accept = cfg_valid && m_ready;
      carry  = 0;
      if (enable) begin
         sum   = m_acc + m_incr;
         carry = (sum >= MODV);
         e     = '{1'b1, wave_of(m_mode, int'(m_acc >> (PW - AW))), m_cflag};
         m_cflag = carry;
         m_acc   = sum % MODV;
      end
      if (m_pending && (m_incr == 0 || carry)) begin
         m_incr = m_pincr;
         m_mode = m_pmode;
         m_pending = 0;
      end
      if (accept) begin
         m_pincr = longint'(cfg_incr);
         m_pmode = int'(cfg_mode);
         m_pending = 1;
      end
      m_live  = 1;
      m_ready = m_live && !m_pending;
      pipe.push_back(e);
      o = pipe.pop_front();
      m_valid = o.v;
      m_wrap  = o.v && o.w;
      if (o.v) m_out = o.val;
   endtask

   bit prev_rst = 1'b0;
   always @(posedge clk) begin
      bit rst_now;
      rst_now = reset;
      model_edge();
      #1;
      check("sample_valid", sample_valid, m_valid);
      check("wrap", wrap, m_wrap);
      check("cfg_ready", cfg_ready, m_ready);
      if (m_valid || rst_now || prev_rst) check("sample_out", sample_out, m_out);
      prev_rst = rst_now;
      if (sample_valid === 1'b1) begin
         log_out.push_back(int'(sample_out));
         log_wrap.push_back(wrap);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_log();
      log_out.delete();
      log_wrap.delete();
   endtask

   task automatic do_reset();
      reset = 1'b1; enable = 1'b0; cfg_valid = 1'b0;
      tick(1);
      check("rst_valid", sample_valid, 0);
      check("rst_ready", cfg_ready, 0);
      check("rst_out", sample_out, 0);
      tick(1);
      reset = 1'b0;
   endtask

   task automatic offer(input logic [PW-1:0] incr, input logic [1:0] mode);
      int k;
      k = 0;
      while (cfg_ready !== 1'b1 && k < 200) begin
         tick(1);
         k++;
      end
      if (cfg_ready !== 1'b1) begin
         n_checks++;
         n_fail++;
         $display("FAIL offer_timeout: cfg_ready=%b required 1", cfg_ready);
      end
      cfg_valid = 1'b1; cfg_incr = incr; cfg_mode = mode;
      tick(1);
      cfg_valid = 1'b0;
   endtask

   task automatic lit(input string name, input int idx, input int eo, input int ew);
      if (idx >= log_out.size()) begin
         check({name, "_count"}, log_out.size(), idx + 1);
      end else begin
         check(name, log_out[idx], eo);
         check({name, "_wrap"}, log_wrap[idx], ew);
      end
   endtask

   int lits [3][4] = '{'{99, 99, 0, 0}, '{0, 25, 50, 75}, '{0, 50, 99, 49}};

   initial begin
      int bad, w1, w2;
      for (int i = 0; i < DEPTH; i++)
         sine_tab[i] = $rtoi($floor(50.0 + 49.5 * $sin(2.0 * PI * real'(i) / real'(DEPTH))));

      // Sine sweep at one table entry per sample, with an enable gap mid-period
      do_reset();
      offer(16'h0100, 2'd0);
      tick(2);
      clear_log();
      enable = 1'b1; tick(270);
      enable = 1'b0; tick(5);
      enable = 1'b1; tick(10);
      enable = 1'b0; tick(3);
      check("sweep_count", log_out.size(), 280);
      bad = 0;
      for (int i = 0; i < log_out.size(); i++) begin
         if (log_out[i] != sine_tab[i % DEPTH]) bad++;
         if (log_wrap[i] != ((i % DEPTH == 0) && i > 0)) bad++;
      end
      check("sweep_continuity", bad, 0);
      lit("sine0", 0, 50, 0);
      lit("sine1", 1, 51, 0);
      lit("sine2", 2, 52, 0);
      lit("sine_peak", 64, 99, 0);
      lit("sine_trough", 192, 0, 0);
      lit("sine_wrap", 256, 50, 1);

      // Square, sawtooth, triangle at four samples per period
      for (int m = 1; m <= 3; m++) begin
         do_reset();
         offer(16'h4000, 2'(m));
         tick(2);
         clear_log();
         enable = 1'b1;
         @(posedge clk); #2;
         check("lat_edge1", sample_valid, 0);
         @(posedge clk); #2;
         check("lat_edge2", sample_valid, 1);
         @(negedge clk);
         tick(7);
         enable = 1'b0; tick(2);
         for (int i = 0; i < 8; i++)
            lit($sformatf("mode%0d_s%0d", m, i), i, lits[m-1][i % 4], (i == 4) ? 1 : 0);
      end

      // Retune mid-period: 4-per-period until the wrap, then 8-per-period
      do_reset();
      offer(16'h4000, 2'd0);
      tick(2);
      enable = 1'b1; tick(6);
      clear_log();
      offer(16'h2000, 2'd0);
      check("ready_fell", cfg_ready, 0);
      tick(20);
      check("ready_rose", cfg_ready, 1);
      w1 = -1; w2 = -1;
      for (int i = 0; i < log_wrap.size(); i++) begin
         if (log_wrap[i]) begin
            if (w1 < 0) w1 = i;
            else if (w2 < 0) w2 = i;
         end
      end
      check("retune_gap", w2 - w1, 8);

      // Reset while a config is pending (accepted on a carry edge), then a fresh config
      do_reset();
      offer(16'h4000, 2'd0);
      tick(2);
      enable = 1'b1; tick(3);
      offer(16'h1000, 2'd2);
      check("pend_ready", cfg_ready, 0);
      tick(1);
      do_reset();
      tick(1);
      check("ready_after_rst", cfg_ready, 1);
      offer(16'h0800, 2'd3);
      check("fresh_pend", cfg_ready, 0);
      tick(1);
      check("fresh_applied", cfg_ready, 1);
      clear_log();
      enable = 1'b1; tick(4);
      enable = 1'b0; tick(2);
      lit("tri0", 0, 0, 0);
      lit("tri1", 1, 6, 0);
      lit("tri2", 2, 12, 0);
      lit("tri3", 3, 18, 0);

      // Random traffic against the model
      do_reset();
      tick(1);
      repeat (4000) begin
         reset     = ($urandom % 600 == 0);
         enable    = ($urandom % 5 != 0);
         cfg_valid = ($urandom % 6 == 0);
         cfg_mode  = 2'($urandom % 4);
         case ($urandom % 5)
            0: cfg_incr = '0;
            1: cfg_incr = PW'($urandom_range(1, 16'h0FFF));
            2: cfg_incr = PW'($urandom_range(16'h1000, 16'h7FFF));
            3: cfg_incr = PW'($urandom_range(16'h8000, 16'hFFFF));
            default: cfg_incr = 16'h4000;
         endcase
         tick(1);
      end
      reset = 1'b0; enable = 1'b0; cfg_valid = 1'b0;
      tick(4);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
